// File: rtl/mac_frame_sched_if.sv
// Bus bundle between the MAC frame sequencer and its environment: frame control,
// operand buffer read port, MAC operand/result lanes and the downstream result handshake.
interface mac_frame_sched_if #(
    parameter int LANES = 5,
    parameter int DW    = 16,
    parameter int ACCW  = 36,
    parameter int KW    = 8,
    parameter int AW    = 10
);
    logic                  start;
    logic [KW-1:0]         k_len;
    logic [AW-1:0]         base_addr;
    logic                  busy;
    logic                  err;

    logic                  op_rd;
    logic [AW-1:0]         op_addr;
    logic [LANES*DW-1:0]   op_a;
    logic [DW-1:0]         op_b;

    logic                  mac_sof;
    logic                  mac_en;
    logic [LANES*DW-1:0]   mac_A;
    logic [DW-1:0]         mac_B;
    logic [LANES*ACCW-1:0] mac_C;
    logic [LANES-1:0]      mac_valid;

    logic [LANES*ACCW-1:0] res_data;
    logic                  res_valid;
    logic                  res_ready;

    // Sequencer side
    modport master (
        input  start, k_len, base_addr, op_a, op_b, mac_C, mac_valid, res_ready,
        output busy, err, op_rd, op_addr, mac_sof, mac_en, mac_A, mac_B, res_data, res_valid
    );

    // Environment side: controller, operand buffer, MAC array and result sink
    modport slave (
        output start, k_len, base_addr, op_a, op_b, mac_C, mac_valid, res_ready,
        input  busy, err, op_rd, op_addr, mac_sof, mac_en, mac_A, mac_B, res_data, res_valid
    );
endinterface

// File: rtl/mac_frame_sched.sv
// Frame sequencer for the multi-lane MAC: streams K operand terms from the operand buffer
// into the MAC, waits for all lanes, captures the accumulators and hands them downstream.
module mac_frame_sched #(
    parameter int LANES = 5,
    parameter int DW    = 16,
    parameter int ACCW  = 36,
    parameter int KW    = 8,
    parameter int AW    = 10,
    parameter int TMO   = 64
) (
    input logic               clk,
    input logic               rst,
    mac_frame_sched_if.master bus
);
    localparam int TW = $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        OUT
    } state_t;

    state_t                state;
    logic                  busy_q;
    logic                  err_q;
    logic                  rd_q;
    logic [AW-1:0]         addr_q;
    logic [KW-1:0]         rem;
    logic                  rd_d;
    logic                  sof_pend;
    logic                  sof_q;
    logic                  en_q;
    logic [LANES*DW-1:0]   a_q;
    logic [DW-1:0]         b_q;
    logic [TW-1:0]         tmo_cnt;
    logic [LANES*ACCW-1:0] res_q;
    logic                  res_valid_q;
    logic                  pipe_idle;

    // The last term has left the operand pipe once neither the read echo nor mac_en is
    // high; before that, mac_valid may still describe the previous frame.
    assign pipe_idle = !rd_d && !en_q;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state here uses non-blocking assignment so every register samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            rem         <= '0;
            rd_d        <= 1'b0;
            sof_pend    <= 1'b0;
            sof_q       <= 1'b0;
            en_q        <= 1'b0;
            // NOTE: the datapath registers are reset too, because the outputs they drive
            // must read zero out of reset rather than hold stale operands.
            a_q         <= '0;
            b_q         <= '0;
            tmo_cnt     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            // Operand pipe: data returns the cycle after a read and is registered once more.
            rd_d <= rd_q;
            if (rd_d) begin
                a_q      <= bus.op_a;
                b_q      <= bus.op_b;
                en_q     <= 1'b1;
                sof_q    <= sof_pend;
                sof_pend <= 1'b0;
            end else begin
                en_q  <= 1'b0;
                sof_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start && (bus.k_len != '0)) begin
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        rd_q     <= 1'b1;
                        addr_q   <= bus.base_addr;
                        rem      <= bus.k_len - KW'(1);
                        sof_pend <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (rem != '0) begin
                        addr_q <= addr_q + AW'(1);
                        rem    <= rem - KW'(1);
                    end else begin
                        rd_q    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (pipe_idle && (&bus.mac_valid)) begin
                        res_q       <= bus.mac_C;
                        res_valid_q <= 1'b1;
                        state       <= OUT;
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.op_rd     = rd_q;
    assign bus.op_addr   = addr_q;
    assign bus.mac_sof   = sof_q;
    assign bus.mac_en    = en_q;
    assign bus.mac_A     = a_q;
    assign bus.mac_B     = b_q;
    assign bus.res_data  = res_q;
    assign bus.res_valid = res_valid_q;
endmodule
